// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared constants, state encoding and sizing helper for serial_subtractor
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - combinational 1-bit full-subtractor cell (x - y - bi)
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit and borrow-out; same cell can be unrolled into a ripple subtractor.
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first A-B-Bin subtractor; SERIAL_SUB_OVF_EN adds signed overflow output ovf
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 most recent result bits; the newest bit completes the word.
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_bo;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign res_next = {cell_d, res_sr};
    assign last     = (cnt == CW'(WIDTH - 1));
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a new op is accepted from IDLE or directly out of DONE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    load       = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand load, one bit per clock while running, result capture on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= bin;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
        end else if (state == ST_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next[WIDTH-1:1];
            br     <= cell_bo;
            cnt    <= cnt + CW'(1);
            if (last) begin
                diff <= res_next;
                bout <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
            end
        end
    end

endmodule
